// File: rtl/obi_ram_pkg.sv
// Shared state encoding, limits and window-decode helper for the OBI SRAM responder.
package obi_ram_pkg;

   typedef enum logic [1:0] {
      RESP_IDLE,
      RESP_WAIT,
      RESP_ACCESS,
      RESP_RESP
   } resp_state_t;

   localparam int unsigned MAX_MEM_LATENCY = 4;
   localparam int unsigned MAX_WAIT_STATES = 7;

   // Evaluated at 64 bits so base + window size cannot wrap for any supported bus width.
   function automatic logic in_window(input logic [63:0] addr, input logic [63:0] base,
                                      input int unsigned aw);
      logic [63:0] size;
      size = 64'd4 << aw;
      return (addr >= base) && (addr < base + size);
   endfunction

endpackage

// File: rtl/obi_ram_responder.sv
// Single-outstanding OBI responder that maps bus accesses onto a synchronous single-port SRAM,
// answering out-of-window addresses with an error response of identical latency.
module obi_ram_responder
   import obi_ram_pkg::*;
#(
   parameter int unsigned               SOC_ADDR_WIDTH = 32,
   parameter int unsigned               MEM_ADDR_WIDTH = 10,
   parameter logic [SOC_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
   parameter int unsigned               MEM_LATENCY    = 1,
   parameter int unsigned               WAIT_STATES    = 0
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      obi_req_i,
   output logic                      obi_gnt_o,
   input  logic [SOC_ADDR_WIDTH-1:0] obi_addr_i,
   input  logic                      obi_we_i,
   input  logic [3:0]                obi_be_i,
   input  logic [31:0]               obi_wdata_i,
   output logic                      obi_rvalid_o,
   output logic [31:0]               obi_rdata_o,
   output logic                      obi_err_o,
   output logic                      mem_req_o,
   output logic                      mem_we_o,
   output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
   output logic [3:0]                mem_be_o,
   output logic [31:0]               mem_wdata_o,
   input  logic [31:0]               mem_rdata_i,
   output logic                      busy_o
);

   if (MEM_LATENCY < 1 || MEM_LATENCY > MAX_MEM_LATENCY) begin : g_badLatency
      $error("obi_ram_responder: MEM_LATENCY must lie in 1..%0d", MAX_MEM_LATENCY);
   end
   if (WAIT_STATES > MAX_WAIT_STATES) begin : g_badWaitStates
      $error("obi_ram_responder: WAIT_STATES must lie in 0..%0d", MAX_WAIT_STATES);
   end
   if (SOC_ADDR_WIDTH > 62 || SOC_ADDR_WIDTH < MEM_ADDR_WIDTH + 2) begin : g_badWidths
      $error("obi_ram_responder: SOC_ADDR_WIDTH incompatible with MEM_ADDR_WIDTH");
   end
   if ((64'(BASE_ADDR) & ((64'd4 << MEM_ADDR_WIDTH) - 64'd1)) != 64'd0) begin : g_badBase
      $error("obi_ram_responder: BASE_ADDR must be aligned to the window size");
   end

   localparam logic [2:0] WAIT_LAST = 3'(WAIT_STATES);
   localparam logic [1:0] LAT_LAST  = 2'(MEM_LATENCY - 1);

   resp_state_t               state_q, state_d;
   logic [2:0]                wCnt_q, wCnt_d;
   logic [1:0]                lCnt_q, lCnt_d;
   logic                      we_q;
   logic                      inRange_q;
   logic                      gnt;
   logic                      inRange;
   logic [MEM_ADDR_WIDTH-1:0] memWord;

   assign inRange = in_window(64'(obi_addr_i), 64'(BASE_ADDR), MEM_ADDR_WIDTH);
   assign memWord = MEM_ADDR_WIDTH'((obi_addr_i - BASE_ADDR) >> 2);

   // Grant decision and next state; a grant jumps straight to RESP when the SRAM answers in one cycle.
   always_comb begin
      state_d = state_q;
      wCnt_d  = wCnt_q;
      lCnt_d  = lCnt_q;
      gnt     = 1'b0;
      unique case (state_q)
         RESP_IDLE: begin
            wCnt_d = '0;
            lCnt_d = '0;
            if (obi_req_i) begin
               if (WAIT_STATES == 0) begin
                  gnt = 1'b1;
               end else begin
                  state_d = RESP_WAIT;
                  wCnt_d  = 3'd1;
               end
            end
         end
         RESP_WAIT: begin
            if (!obi_req_i) begin
               state_d = RESP_IDLE;
               wCnt_d  = '0;
            end else if (wCnt_q == WAIT_LAST) begin
               gnt = 1'b1;
            end else begin
               wCnt_d = wCnt_q + 3'd1;
            end
         end
         RESP_ACCESS: begin
            if (lCnt_q == LAT_LAST) begin
               state_d = RESP_RESP;
            end else begin
               lCnt_d = lCnt_q + 2'd1;
            end
         end
         RESP_RESP: begin
            state_d = RESP_IDLE;
         end
         default: begin
            state_d = RESP_IDLE;
         end
      endcase
      if (gnt) begin
         wCnt_d = '0;
         if (MEM_LATENCY == 1) begin
            state_d = RESP_RESP;
         end else begin
            state_d = RESP_ACCESS;
            lCnt_d  = 2'd1;
         end
      end
   end

   // State, counters and the per-transaction attributes captured at grant.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= RESP_IDLE;
         wCnt_q    <= '0;
         lCnt_q    <= '0;
         we_q      <= 1'b0;
         inRange_q <= 1'b0;
      end else begin
         state_q <= state_d;
         wCnt_q  <= wCnt_d;
         lCnt_q  <= lCnt_d;
         if (obi_gnt_o) begin
            we_q      <= obi_we_i;
            inRange_q <= inRange;
         end
      end
   end

   // A grant is never issued in a reset cycle, since the reset would discard it.
   assign obi_gnt_o    = gnt & ~rst_i;
   assign mem_req_o    = obi_gnt_o & inRange;
   assign mem_we_o     = mem_req_o & obi_we_i;
   assign mem_addr_o   = mem_req_o ? memWord : '0;
   assign mem_be_o     = mem_req_o ? obi_be_i : 4'h0;
   assign mem_wdata_o  = mem_req_o ? obi_wdata_i : 32'h0;
   assign obi_rvalid_o = (state_q == RESP_RESP);
   assign obi_err_o    = obi_rvalid_o & ~inRange_q;
   assign obi_rdata_o  = (obi_rvalid_o & ~we_q & inRange_q) ? mem_rdata_i : 32'h0;
   assign busy_o       = (state_q != RESP_IDLE);

endmodule

// File: tb/tb_obi_ram_responder.sv
// Self-checking bench: three responder configurations against a transaction-level reference model,
// directed scenarios with literal expectations, then randomized traffic with occasional resets.
module tb_obi_ram_responder;

   localparam int          NDUT = 3;
   localparam int          WS_TAB   [NDUT] = '{0, 3, 0};
   localparam int          LAT_TAB  [NDUT] = '{1, 2, 3};
   localparam logic [31:0] BASE_TAB [NDUT] = '{32'h0000_0000, 32'h1000_0000, 32'h0000_0000};

   logic        clk;
   logic        rst      [NDUT];
   logic        req      [NDUT];
   logic        we       [NDUT];
   logic [31:0] addr     [NDUT];
   logic [3:0]  be       [NDUT];
   logic [31:0] wdata    [NDUT];
   logic        gnt      [NDUT];
   logic        rvalid   [NDUT];
   logic [31:0] rdata    [NDUT];
   logic        err      [NDUT];
   logic        memReq   [NDUT];
   logic        memWe    [NDUT];
   logic [9:0]  memAddr  [NDUT];
   logic [3:0]  memBe    [NDUT];
   logic [31:0] memWdata [NDUT];
   logic [31:0] memRdata [NDUT];
   logic        busy     [NDUT];

   logic [31:0] sram [NDUT][1024];
   logic [31:0] pipe [NDUT][4];
   logic        loaded = 1'b0;

   int cyc = 0;
   int nChecks = 0;
   int nFails = 0;
   int gntCount [NDUT];
   int rvCount  [NDUT];

   // Reference model state: all expectations come from these, never from the DUT.
   int          lastG      [NDUT];
   int          run        [NDUT];
   bit          respValid  [NDUT];
   int          respCycle  [NDUT];
   logic        respErr    [NDUT];
   logic [31:0] respRdata  [NDUT];
   logic [31:0] shadow     [NDUT][1024];

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] initWord(input int i);
      return (i == 5) ? 32'h1122_3344 : 32'(i) * 32'h9E37_79B1;
   endfunction

   for (genvar k = 0; k < NDUT; k++) begin : g_dut
      obi_ram_responder #(
         .SOC_ADDR_WIDTH(32),
         .MEM_ADDR_WIDTH(10),
         .BASE_ADDR     (BASE_TAB[k]),
         .MEM_LATENCY   (LAT_TAB[k]),
         .WAIT_STATES   (WS_TAB[k])
      ) u_dut (
         .clk_i       (clk),
         .rst_i       (rst[k]),
         .obi_req_i   (req[k]),
         .obi_gnt_o   (gnt[k]),
         .obi_addr_i  (addr[k]),
         .obi_we_i    (we[k]),
         .obi_be_i    (be[k]),
         .obi_wdata_i (wdata[k]),
         .obi_rvalid_o(rvalid[k]),
         .obi_rdata_o (rdata[k]),
         .obi_err_o   (err[k]),
         .mem_req_o   (memReq[k]),
         .mem_we_o    (memWe[k]),
         .mem_addr_o  (memAddr[k]),
         .mem_be_o    (memBe[k]),
         .mem_wdata_o (memWdata[k]),
         .mem_rdata_i (memRdata[k]),
         .busy_o      (busy[k])
      );
      assign memRdata[k] = pipe[k][LAT_TAB[k]-1];
   end

   // SRAM macro models: read data appears LAT cycles after the strobe, junk otherwise.
   always @(posedge clk) begin
      loaded <= 1'b1;
      for (int k = 0; k < NDUT; k++) begin
         if (!loaded) begin
            for (int i = 0; i < 1024; i++) sram[k][i] <= initWord(i);
         end else if (memReq[k] && memWe[k]) begin
            for (int b = 0; b < 4; b++)
               if (memBe[k][b]) sram[k][memAddr[k]][8*b +: 8] <= memWdata[k][8*b +: 8];
         end
         pipe[k][0] <= (memReq[k] && !memWe[k]) ? sram[k][memAddr[k]] : $urandom;
         for (int j = 1; j < 4; j++) pipe[k][j] <= pipe[k][j-1];
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One cycle of the reference model for configuration k: predict, compare, then advance.
   task automatic modelStep(input int k);
      longint      a, b;
      bit          inr, free, eGnt, eBusy, eRv;
      int          idx;
      logic [31:0] eRd;
      a    = longint'(addr[k]);
      b    = longint'(BASE_TAB[k]);
      inr  = (a >= b) && (a < b + 4096);
      idx  = inr ? int'((a - b) / 4) : 0;
      free = !(cyc > lastG[k] && cyc <= lastG[k] + LAT_TAB[k]);
      eGnt = !rst[k] && free && req[k] && (run[k] == WS_TAB[k]);
      eBusy = !free || (run[k] > 0);
      eRv  = respValid[k] && (cyc == respCycle[k]);
      eRd  = eRv ? respRdata[k] : 32'h0;
      checkOutput($sformatf("gnt[%0d]", k), gnt[k], eGnt);
      checkOutput($sformatf("busy[%0d]", k), busy[k], eBusy);
      checkOutput($sformatf("rvalid[%0d]", k), rvalid[k], eRv);
      checkOutput($sformatf("err[%0d]", k), err[k], eRv && respErr[k]);
      checkOutput($sformatf("rdata[%0d]", k), rdata[k], eRd);
      checkOutput($sformatf("memReq[%0d]", k), memReq[k], eGnt && inr);
      checkOutput($sformatf("memWe[%0d]", k), memWe[k], eGnt && inr && we[k]);
      checkOutput($sformatf("memAddr[%0d]", k), memAddr[k], (eGnt && inr) ? idx : 0);
      checkOutput($sformatf("memBe[%0d]", k), memBe[k], (eGnt && inr) ? be[k] : 4'h0);
      checkOutput($sformatf("memWdata[%0d]", k), memWdata[k], (eGnt && inr) ? wdata[k] : 32'h0);
      if (gnt[k]) gntCount[k]++;
      if (rvalid[k]) rvCount[k]++;
      if (rst[k]) begin
         run[k] = 0;
         lastG[k] = -100;
         respValid[k] = 1'b0;
      end else if (eGnt) begin
         lastG[k] = cyc;
         run[k] = 0;
         respValid[k] = 1'b1;
         respCycle[k] = cyc + LAT_TAB[k];
         respErr[k] = !inr;
         respRdata[k] = (inr && !we[k]) ? shadow[k][idx] : 32'h0;
         if (inr && we[k])
            for (int i = 0; i < 4; i++)
               if (be[k][i]) shadow[k][idx][8*i +: 8] = wdata[k][8*i +: 8];
      end else if (free && req[k]) begin
         run[k]++;
      end else begin
         run[k] = 0;
      end
   endtask

   initial begin
      for (int k = 0; k < NDUT; k++) begin
         for (int i = 0; i < 1024; i++) shadow[k][i] = initWord(i);
         lastG[k] = -100;
         run[k] = 0;
         respValid[k] = 1'b0;
         respCycle[k] = 0;
         respErr[k] = 1'b0;
         respRdata[k] = 32'h0;
         gntCount[k] = 0;
         rvCount[k] = 0;
      end
      forever begin
         @(negedge clk);
         for (int k = 0; k < NDUT; k++) modelStep(k);
      end
   end

   // Full bus transaction on configuration k; returns start, grant and response cycles.
   task automatic busTxn(input int k, input logic w, input logic [31:0] a, input logic [3:0] bEn,
                         input logic [31:0] d, output int sC, output int gC, output int rC,
                         output logic [31:0] rd, output logic e, output logic mReq,
                         output logic [9:0] mAddr, output logic [3:0] mBe);
      gC = -1; rC = -1; rd = '0; e = 1'b0; mReq = 1'b0; mAddr = '0; mBe = '0;
      @(posedge clk); #1;
      sC = cyc;
      req[k] = 1'b1; we[k] = w; addr[k] = a; be[k] = bEn; wdata[k] = d;
      for (int n = 0; n < 40 && gC < 0; n++) begin
         @(negedge clk);
         if (gnt[k]) begin
            gC = cyc; mReq = memReq[k]; mAddr = memAddr[k]; mBe = memBe[k];
         end
         @(posedge clk); #1;
      end
      req[k] = 1'b0;
      for (int n = 0; n < 40 && rC < 0; n++) begin
         @(negedge clk);
         if (rvalid[k]) begin
            rC = cyc; rd = rdata[k]; e = err[k];
         end
      end
      checkOutput($sformatf("txn%0d_completed", k), (gC >= 0) && (rC >= 0), 1);
   endtask

   task automatic applyStimulus();
      @(posedge clk); #1;
      for (int k = 0; k < NDUT; k++) begin
         rst[k] = ($urandom_range(0, 199) == 0);
         req[k] = ($urandom_range(0, 9) < ((k == 1) ? 9 : 6));
         we[k] = 1'($urandom_range(0, 1));
         be[k] = 4'($urandom_range(0, 15));
         wdata[k] = $urandom;
         case ($urandom_range(0, 9))
            0:       addr[k] = $urandom;
            1:       addr[k] = BASE_TAB[k] + 32'h1000 + 32'($urandom_range(0, 3));
            2:       addr[k] = BASE_TAB[k] - 32'd1;
            3, 4, 5: addr[k] = BASE_TAB[k] + 32'($urandom_range(0, 63));
            default: addr[k] = BASE_TAB[k] + 32'($urandom_range(0, 4095));
         endcase
      end
   endtask

   int          sC, gC, rC, s, c0, r0;
   logic [31:0] rd;
   logic        e, mReq;
   logic [9:0]  mAddr;
   logic [3:0]  mBe;

   initial begin
      for (int k = 0; k < NDUT; k++) begin
         rst[k] = 1'b1; req[k] = 1'b0; we[k] = 1'b0;
         addr[k] = '0; be[k] = '0; wdata[k] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < NDUT; k++) rst[k] = 1'b0;
      @(negedge clk);
      checkOutput("reset_busy", busy[0], 0);
      checkOutput("reset_rvalid", rvalid[1], 0);
      checkOutput("reset_memreq", memReq[2], 0);

      // Defaults: write then read back at 0x10.
      busTxn(0, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, sC, gC, rC, rd, e, mReq, mAddr, mBe);
      checkOutput("t1_wr_grant_at_req", gC - sC, 0);
      checkOutput("t1_wr_memreq", mReq, 1);
      checkOutput("t1_wr_memaddr", mAddr, 10'h004);
      checkOutput("t1_wr_latency", rC - gC, 1);
      checkOutput("t1_wr_err", e, 0);
      checkOutput("t1_wr_rdata", rd, 0);
      busTxn(0, 1'b0, 32'h10, 4'hF, 32'h0, sC, gC, rC, rd, e, mReq, mAddr, mBe);
      checkOutput("t1_rd_latency", rC - gC, 1);
      checkOutput("t1_rd_data", rd, 32'hDEAD_BEEF);

      // Byte-enable merge into the preloaded word at 0x14.
      busTxn(0, 1'b1, 32'h14, 4'h2, 32'h0000_AB00, sC, gC, rC, rd, e, mReq, mAddr, mBe);
      checkOutput("t2_membe", mBe, 4'h2);
      busTxn(0, 1'b0, 32'h14, 4'hF, 32'h0, sC, gC, rC, rd, e, mReq, mAddr, mBe);
      checkOutput("t2_rd_merged", rd, 32'h1122_AB44);

      // Three wait states, latency two.
      busTxn(1, 1'b0, 32'h1000_0010, 4'hF, 32'h0, sC, gC, rC, rd, e, mReq, mAddr, mBe);
      checkOutput("t3_gnt_cycle", gC - sC, 3);
      checkOutput("t3_rvalid_cycle", rC - sC, 5);
      @(posedge clk); #1;
      s = cyc; c0 = gntCount[1];
      req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h1000_0020;
      @(posedge clk); #1;
      @(posedge clk); #1;
      req[1] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("t3_drop_busy", busy[1], 0);
      checkOutput("t3_drop_cycle", cyc - s, 3);
      @(posedge clk); #1;
      checkOutput("t3_drop_no_gnt", gntCount[1] - c0, 0);

      // Back-to-back requests on defaults: grant every other cycle.
      s = cyc; c0 = gntCount[0]; r0 = rvCount[0];
      req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h20;
      repeat (8) @(posedge clk);
      #1;
      req[0] = 1'b0;
      checkOutput("t4_gnt_count", gntCount[0] - c0, 4);
      checkOutput("t4_rvalid_count", rvCount[0] - r0, 4);

      // Window decode with a non-zero base.
      busTxn(1, 1'b0, 32'h0000_0040, 4'hF, 32'h0, sC, gC, rC, rd, e, mReq, mAddr, mBe);
      checkOutput("t5_low_memreq", mReq, 0);
      checkOutput("t5_low_err", e, 1);
      checkOutput("t5_low_rdata", rd, 0);
      checkOutput("t5_low_latency", rC - gC, 2);
      busTxn(1, 1'b0, 32'h1000_0FFC, 4'hF, 32'h0, sC, gC, rC, rd, e, mReq, mAddr, mBe);
      checkOutput("t5_top_memaddr", mAddr, 10'h3FF);
      checkOutput("t5_top_err", e, 0);
      busTxn(1, 1'b1, 32'h1000_1000, 4'hF, 32'h1234_5678, sC, gC, rC, rd, e, mReq, mAddr, mBe);
      checkOutput("t5_above_err", e, 1);
      checkOutput("t5_above_memreq", mReq, 0);

      // Reset abandons an in-flight access on the latency-three configuration.
      busTxn(2, 1'b1, 32'h10, 4'hF, 32'h5A5A_0001, sC, gC, rC, rd, e, mReq, mAddr, mBe);
      @(posedge clk); #1;
      r0 = rvCount[2];
      req[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'h20;
      @(negedge clk);
      checkOutput("t6_gnt", gnt[2], 1);
      @(posedge clk); #1;
      req[2] = 1'b0; rst[2] = 1'b1;
      @(posedge clk); #1;
      rst[2] = 1'b0;
      @(negedge clk);
      checkOutput("t6_busy_after_rst", busy[2], 0);
      repeat (6) @(posedge clk);
      #1;
      checkOutput("t6_no_rvalid", rvCount[2] - r0, 0);
      busTxn(2, 1'b0, 32'h10, 4'hF, 32'h0, sC, gC, rC, rd, e, mReq, mAddr, mBe);
      checkOutput("t6_after_latency", rC - gC, 3);
      checkOutput("t6_after_data", rd, 32'h5A5A_0001);
      checkOutput("t6_after_err", e, 0);

      repeat (500) applyStimulus();
      @(posedge clk); #1;
      for (int k = 0; k < NDUT; k++) begin
         rst[k] = 1'b0;
         req[k] = 1'b0;
      end
      repeat (8) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
